// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states,
// bus widths and the "nothing to claim" read value.
package int_ctrl_pkg;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_PEND  = 2'd0;
    localparam logic [ADDR_W-1:0] REG_MASK  = 2'd1;
    localparam logic [ADDR_W-1:0] REG_CLAIM = 2'd2;
    localparam logic [ADDR_W-1:0] REG_EOI   = 2'd3;

    localparam logic [DATA_W-1:0] NO_IRQ = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/int_ctrl_if.sv
// Register bus between the CPU (master) and the interrupt controller (slave).
//   sel   : block select
//   we    : write enable, qualified by sel
//   addr  : register index
//   wdata : write data
//   rdata : registered read data, valid the cycle after a read
interface int_ctrl_if;
    import int_ctrl_pkg::*;

    logic              sel;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (output sel, output we, output addr, output wdata, input rdata);
    modport slave  (input sel, input we, input addr, input wdata, output rdata);

endinterface

// File: rtl/int_prio_enc.sv
// Combinational lowest-index-wins priority encoder.
//   vec   : request vector, bit 0 highest priority
//   valid : any bit of vec set
//   id    : index of the lowest set bit (0 when none)
module int_prio_enc #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 5
) (
    input  logic [N-1:0]    vec,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scan from the top so the lowest set index is the last assignment.
    always_comb begin
        valid = |vec;
        id    = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: latches rising edges of irq_in as
// pending, masks them, picks the lowest-index active source and drives int0,
// then sequences the CLAIM / EOI handshake with the CPU handler.
//   clk, rst : clock, synchronous active-high reset
//   irq_in   : level requests from peripherals
//   bus      : register bus (PEND, MASK, CLAIM, EOI)
//   int0     : registered interrupt request to the CPU
// ID_W must satisfy 2**ID_W >= N_SRC.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned ID_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_in,
    int_ctrl_if.slave        bus,
    output logic             int0
);

    state_t            state_q, state_d;
    logic [N_SRC-1:0]  pend_q, mask_q, irq_d_q;
    logic [ID_W-1:0]   cur_id_q;
    logic [DATA_W-1:0] rdata_q;
    logic              int0_q;

    logic [N_SRC-1:0]  act, edge_det, w1c, claim_clr, pend_d;
    logic              act_valid;
    logic [ID_W-1:0]   win_id;
    logic              rd_en, wr_en, claim_rd, eoi_wr, claim_take, int0_d;
    logic [DATA_W-1:0] rd_val;
    logic              unused_wdata;

    assign rd_en    = bus.sel & ~bus.we;
    assign wr_en    = bus.sel & bus.we;
    assign claim_rd = rd_en & (bus.addr == REG_CLAIM);
    assign eoi_wr   = wr_en & (bus.addr == REG_EOI);
    assign act      = pend_q & mask_q;
    assign edge_det = irq_in & ~irq_d_q;

    // Upper write-data bits and EOI data carry no meaning.
    assign unused_wdata = ^bus.wdata;

    int_prio_enc #(
        .N    (N_SRC),
        .ID_W (ID_W)
    ) u_prio (
        .vec   (act),
        .valid (act_valid),
        .id    (win_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; losing every active source in REQ takes priority over a claim.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (act_valid) state_d = REQ;
            REQ: begin
                if (!act_valid)    state_d = IDLE;
                else if (claim_rd) state_d = SERVICE;
            end
            SERVICE: if (eoi_wr) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Claim side effects, pending update, int0 and read mux.
    always_comb begin
        claim_take = claim_rd & (state_q == REQ) & act_valid;
        claim_clr  = claim_take ? (N_SRC'(1) << win_id) : '0;
        w1c        = (wr_en && (bus.addr == REG_PEND)) ? bus.wdata[N_SRC-1:0] : '0;
        // A fresh edge beats both W1C and the claim clear on the same bit.
        pend_d     = (pend_q & ~w1c & ~claim_clr) | edge_det;
        int0_d     = (state_d == REQ);
        rd_val     = '0;
        unique case (bus.addr)
            REG_PEND:  rd_val = DATA_W'(pend_q);
            REG_MASK:  rd_val = DATA_W'(mask_q);
            REG_CLAIM: rd_val = claim_take ? DATA_W'(win_id) : NO_IRQ;
            // EOI is write-only; a read shows the id currently in service.
            REG_EOI:   rd_val = DATA_W'(cur_id_q);
            default:   rd_val = '0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q   <= '0;
            mask_q   <= '0;
            irq_d_q  <= '0;
            cur_id_q <= '0;
            int0_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            irq_d_q <= irq_in;
            pend_q  <= pend_d;
            int0_q  <= int0_d;
            if (wr_en && (bus.addr == REG_MASK)) begin
                mask_q <= bus.wdata[N_SRC-1:0];
            end
            if (claim_take) begin
                cur_id_q <= win_id;
            end
            if (rd_en) begin
                rdata_q <= rd_val;
            end
        end
    end

    assign bus.rdata = rdata_q;
    assign int0      = int0_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: reads push expected data into a scoreboard
// queue, a monitor pops and compares when read data becomes valid.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    typedef struct {
        string             name;
        logic [DATA_W-1:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] irq_in;
    logic       int0;

    int_ctrl_if bus_if ();

    int_ctrl #(
        .N_SRC (4),
        .ID_W  (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .bus    (bus_if.slave),
        .int0   (int0)
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_issued = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data is valid the cycle after a non-reset read strobe.
    always @(posedge clk) rd_issued <= bus_if.sel && !bus_if.we && !rst;

    always @(negedge clk) begin
        if (rd_issued) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h with no expected entry", bus_if.rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus_if.rdata !== e.val) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, bus_if.rdata, e.val);
                end
            end
        end
    end

    task automatic chk_int0(input string name, input logic exp);
        checks++;
        if (int0 !== exp) begin
            errors++;
            $display("FAIL %s: int0 got %b expected %b", name, int0, exp);
        end
    endtask

    task automatic wait_int0(input string name, input logic exp, input int budget);
        int n = 0;
        while (n < budget && int0 !== exp) begin
            @(negedge clk);
            n++;
        end
        chk_int0(name, exp);
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.name = name;
        e.val  = exp;
        exp_q.push_back(e);
        bus_if.sel  = 1'b1;
        bus_if.we   = 1'b0;
        bus_if.addr = a;
        @(negedge clk);
        bus_if.sel  = 1'b0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus_if.sel   = 1'b1;
        bus_if.we    = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        @(negedge clk);
        bus_if.sel   = 1'b0;
        bus_if.we    = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] v);
        irq_in = v;
        @(negedge clk);
        irq_in = 4'b0000;
    endtask

    initial begin
        rst          = 1'b1;
        irq_in       = 4'b0000;
        bus_if.sel   = 1'b0;
        bus_if.we    = 1'b0;
        bus_if.addr  = 2'd0;
        bus_if.wdata = 32'd0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values and unimplemented bits.
        chk_int0("rst_int0", 1'b0);
        bus_rd(REG_PEND,  32'h0, "rst_pend");
        bus_rd(REG_MASK,  32'h0, "rst_mask");
        bus_rd(REG_CLAIM, NO_IRQ, "rst_claim");
        bus_rd(REG_EOI,   32'h0, "rst_cur_id");
        bus_wr(REG_MASK, 32'hFFFF_FFF0);
        bus_rd(REG_MASK,  32'h0, "mask_upper_bits");

        // Single source.
        bus_wr(REG_MASK, 32'h2);
        pulse(4'b0010);
        wait_int0("ss_int0_rise", 1'b1, 4);
        bus_rd(REG_CLAIM, 32'd1, "ss_claim");
        chk_int0("ss_int0_fall", 1'b0);
        bus_rd(REG_PEND,  32'h0, "ss_pend_cleared");
        bus_rd(REG_EOI,   32'd1, "ss_cur_id");
        bus_wr(REG_EOI, 32'h0);
        repeat (2) @(negedge clk);
        chk_int0("ss_after_eoi", 1'b0);
        bus_rd(REG_CLAIM, NO_IRQ, "ss_claim_idle");

        // Priority between sources 0 and 3.
        bus_wr(REG_MASK, 32'hF);
        pulse(4'b1001);
        wait_int0("pr_int0_rise", 1'b1, 4);
        bus_rd(REG_CLAIM, 32'd0, "pr_claim_first");
        chk_int0("pr_int0_fall", 1'b0);
        bus_rd(REG_PEND,  32'h8, "pr_pend_left");
        bus_wr(REG_EOI, 32'h0);
        chk_int0("pr_eoi_gap", 1'b0);
        @(negedge clk);
        chk_int0("pr_reraise", 1'b1);
        bus_rd(REG_CLAIM, 32'd3, "pr_claim_second");
        bus_wr(REG_EOI, 32'h0);

        // Masking while in REQ.
        pulse(4'b0100);
        wait_int0("mk_int0_rise", 1'b1, 4);
        bus_wr(REG_MASK, 32'h0);
        chk_int0("mk_int0_hold", 1'b1);
        @(negedge clk);
        chk_int0("mk_int0_drop", 1'b0);
        bus_rd(REG_PEND,  32'h4, "mk_pend_kept");
        bus_wr(REG_MASK, 32'h4);
        chk_int0("mk_unmask_lag", 1'b0);
        @(negedge clk);
        chk_int0("mk_unmask_rise", 1'b1);
        bus_rd(REG_CLAIM, 32'd2, "mk_claim");
        bus_wr(REG_EOI, 32'h0);

        // Edge during SERVICE colliding with W1C, plus spurious CLAIM.
        bus_wr(REG_MASK, 32'hF);
        pulse(4'b0010);
        wait_int0("sv_int0_rise", 1'b1, 4);
        bus_rd(REG_CLAIM, 32'd1, "sv_claim");
        irq_in = 4'b0010;
        bus_wr(REG_PEND, 32'h2);
        irq_in = 4'b0000;
        bus_rd(REG_PEND,  32'h2, "sv_set_beats_w1c");
        chk_int0("sv_int0_low", 1'b0);
        bus_rd(REG_CLAIM, NO_IRQ, "sv_spurious_claim");
        bus_rd(REG_EOI,   32'd1, "sv_cur_id_kept");
        chk_int0("sv_still_service", 1'b0);
        bus_wr(REG_EOI, 32'h0);
        chk_int0("sv_eoi_gap", 1'b0);
        @(negedge clk);
        chk_int0("sv_reraise", 1'b1);
        bus_rd(REG_CLAIM, 32'd1, "sv_claim_again");
        bus_wr(REG_EOI, 32'h0);

        // EOI in IDLE and in REQ is ignored.
        bus_wr(REG_EOI, 32'h0);
        repeat (2) @(negedge clk);
        chk_int0("idle_eoi_int0", 1'b0);
        bus_rd(REG_CLAIM, NO_IRQ, "idle_eoi_claim");
        pulse(4'b0100);
        wait_int0("req_int0_rise", 1'b1, 4);
        bus_wr(REG_EOI, 32'h0);
        chk_int0("req_eoi_ignored", 1'b1);
        bus_rd(REG_CLAIM, 32'd2, "req_claim");

        // Reset while in SERVICE with another source pending.
        pulse(4'b0001);
        bus_rd(REG_PEND, 32'h1, "pre_rst_pend");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_int0("rst2_int0", 1'b0);
        bus_rd(REG_PEND,  32'h0, "rst2_pend");
        bus_rd(REG_MASK,  32'h0, "rst2_mask");
        bus_rd(REG_EOI,   32'h0, "rst2_cur_id");
        bus_rd(REG_CLAIM, NO_IRQ, "rst2_claim");
        bus_wr(REG_MASK, 32'hF);
        repeat (3) @(negedge clk);
        chk_int0("rst2_no_residual", 1'b0);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Memory-mapped interrupt controller in cpu_perefery, between peripheral interrupt sources (UART receiver, timers, GPIO) and the CPU's single int0 input.
- Latches rising edges of each irq source as pending, applies a mask, arbitrates by fixed priority and drives int0.
- Sequences the claim / end-of-interrupt (EOI) handshake with the CPU's handler through four bus registers.

Parameters:
- N_SRC, 4, number of interrupt sources (1..32); bit 0 = highest priority.
- ID_W, 5, width of the source-id field; must satisfy 2**ID_W >= N_SRC.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  N_SRC  level requests from peripherals; a rising edge latches pending.
- sel  in  1  bus select for this block.
- we  in  1  write enable; valid with sel.
- addr  in  2  register index.
- wdata  in  32  write data.
- rdata  out  32  registered read data.
- int0  out  1  registered interrupt request to the CPU.

Behaviour:
- Registers:
  - 0 PEND: read; write-1-to-clear.
  - 1 MASK: read/write; 1 = enabled.
  - 2 CLAIM: read only; reading is the claim.
  - 3 EOI: write only; data ignored.
- Bits at and above N_SRC read 0 and ignore writes.
- Reset (rst sampled high at a clk edge):
  - pend=0, mask=0, irq_d=0, state=IDLE, int0=0, rdata=0, cur_id=0.
  - Reset mid-handshake abandons the claim with no residual state.
- Edge detect: irq_d <= irq_in. pend[i] sets when irq_in[i] & ~irq_d[i].
  - Same-cycle set and W1C on one bit: set wins.
- Active set: act = pend & mask. Winner = lowest set index of act.
- FSM, states IDLE, REQ, SERVICE; int0 <= (next_state == REQ):
  - IDLE -> REQ when act != 0. int0 rises on the same edge the state enters REQ.
  - REQ -> IDLE when act becomes 0 before a claim (masked or W1C). int0 falls on the same edge.
  - REQ -> SERVICE on a CLAIM read:
    - Winner is recomputed in the claim cycle.
    - cur_id <= winner.
    - pend[winner] cleared, unless a new edge on that source arrives the same cycle (set wins).
    - int0 falls.
  - SERVICE -> IDLE on an EOI write. Next evaluation happens in IDLE on the following cycle, so a still-pending source re-raises int0 2 cycles after EOI.
  - EOI in IDLE/REQ: ignored. CLAIM read in IDLE/SERVICE: returns 0xFFFF_FFFF, no state change.
- Edges arriving in SERVICE still latch into pend; there is no nesting.
- Reads: rdata <= register value one cycle after sel & ~we.
  - rdata holds its value when there is no read.
  - CLAIM read data: zero-extended winner id.
- Writes take effect at the clk edge where sel & we.
- A MASK write affects act from the next cycle.

Decomposition:
- Shared package int_ctrl_pkg:
  - register offsets REG_PEND=0, REG_MASK=1, REG_CLAIM=2, REG_EOI=3;
  - state enum IDLE/REQ/SERVICE (2-bit);
  - constant NO_IRQ=32'hFFFF_FFFF.
- One sub-module int_prio_enc: combinational lowest-index priority encoder, N_SRC-bit vector in, outputs valid + ID_W id. Reused by the future DMA arbiter.

Test Plan:
- Reset values: hold rst 4 cycles, then release -> int0=0, reads of PEND/MASK=0, CLAIM=0xFFFF_FFFF.
- Single source: MASK=4'b0010, pulse irq_in[1] for 1 cycle -> int0=1 at that edge; CLAIM read -> rdata=1 next cycle, int0=0, PEND=0; EOI -> IDLE, int0 stays 0.
- Priority: MASK=4'hF, edges on sources 3 and 0 in the same cycle -> first CLAIM=0; after EOI, int0 rises 2 cycles later and the second CLAIM=3.
- Masking in REQ: pending on source 2 with int0=1, write MASK=0 -> int0=0 next cycle, PEND still 4'b0100; write MASK=4'b0100 -> int0=1 again.
- Edge during SERVICE plus same-cycle W1C: in SERVICE, edge on source 1 coincides with a PEND write of 4'b0010 -> PEND bit 1 stays 1; after EOI, int0 reasserts.
- Spurious accesses: EOI in IDLE -> no effect; CLAIM read in SERVICE -> 0xFFFF_FFFF, state and cur_id unchanged; rst asserted in SERVICE -> IDLE, all zero.
